// File: rtl/risc_pkg.sv
// Shared constants for the 8-bit accumulator CPU.
// Opcode encoding, instruction-cycle phases and ALU-opcode classification.
package risc_pkg;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    typedef enum logic [2:0] {
        PH_INST_ADDR  = 3'd0,
        PH_INST_FETCH = 3'd1,
        PH_INST_LOAD  = 3'd2,
        PH_IDLE       = 3'd3,
        PH_OP_ADDR    = 3'd4,
        PH_OP_FETCH   = 3'd5,
        PH_ALU_OP     = 3'd6,
        PH_STORE      = 3'd7
    } phase_e;

    function automatic logic is_aluop(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_AND) ||
               (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/risc_controller.sv
// Instruction sequencer: 8-phase cycle counter, opcode latch
// and the strobe decode for bus, register file and memory.
module risc_controller
    import risc_pkg::*;
#(
    parameter int OP_W        = 3,
    parameter bit HALT_FREEZE = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OP_W-1:0] opcode,
    input  logic            zero,
    output logic            sel,
    output logic            rd,
    output logic            ld_ir,
    output logic            inc_pc,
    output logic            ld_pc,
    output logic            data_e,
    output logic            ld_ac,
    output logic            wr,
    output logic            halt,
    output logic [2:0]      phase
);

    phase_e          phase_q;
    phase_e          phase_d;
    logic [OP_W-1:0] op_q;
    logic            aluop;
    logic            frozen;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH_INST_ADDR;
            op_q    <= OP_HLT;
        end else begin
            phase_q <= phase_d;
            if (phase_q == PH_IDLE)
                op_q <= opcode;
        end
    end

    assign aluop  = is_aluop(op_q);
    assign frozen = HALT_FREEZE && (phase_q == PH_OP_ADDR) && (op_q == OP_HLT);
    assign phase  = phase_q;

    always_comb begin
        phase_d = frozen ? phase_q : phase_e'(phase_q + 3'd1);
        sel     = 1'b0;
        rd      = 1'b0;
        ld_ir   = 1'b0;
        inc_pc  = 1'b0;
        ld_pc   = 1'b0;
        data_e  = 1'b0;
        ld_ac   = 1'b0;
        wr      = 1'b0;
        halt    = 1'b0;
        unique case (phase_q)
            PH_INST_ADDR: begin
                sel = 1'b1;
            end
            PH_INST_FETCH: begin
                sel = 1'b1;
                rd  = 1'b1;
            end
            PH_INST_LOAD, PH_IDLE: begin
                sel   = 1'b1;
                rd    = 1'b1;
                ld_ir = 1'b1;
            end
            PH_OP_ADDR: begin
                halt   = (op_q == OP_HLT);
                inc_pc = (op_q != OP_HLT);
            end
            PH_OP_FETCH: begin
                rd = aluop;
            end
            PH_ALU_OP: begin
                // zero only matters here, for SKZ
                rd     = aluop;
                inc_pc = (op_q == OP_SKZ) && zero;
                ld_pc  = (op_q == OP_JMP);
                data_e = (op_q == OP_STO);
            end
            PH_STORE: begin
                rd     = aluop;
                ld_ac  = aluop;
                ld_pc  = (op_q == OP_JMP);
                inc_pc = (op_q == OP_JMP);
                wr     = (op_q == OP_STO);
                data_e = (op_q == OP_STO);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_risc_controller.sv
// Randomized bench for risc_controller against a phase/opcode
// reference model derived from the instruction-cycle table.
module tb_risc_controller;

    logic       clk;
    logic       rst_n;
    logic [2:0] opcode;
    logic       zero;
    logic       sel, rd, ld_ir, inc_pc, ld_pc;
    logic       data_e, ld_ac, wr, halt;
    logic [2:0] phase;

    int total;
    int bad;

    int         m_ph;
    logic [2:0] m_op;
    int         halt_cnt;
    int         resets_mid;
    int         halts_seen;

    risc_controller dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .opcode (opcode),
        .zero   (zero),
        .sel    (sel),
        .rd     (rd),
        .ld_ir  (ld_ir),
        .inc_pc (inc_pc),
        .ld_pc  (ld_pc),
        .data_e (data_e),
        .ld_ac  (ld_ac),
        .wr     (wr),
        .halt   (halt),
        .phase  (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (model phase %0d op %0d)",
                     tag, got, exp, m_ph, m_op);
        end
    endtask

    // {sel,rd,ld_ir,inc_pc,ld_pc,data_e,ld_ac,wr,halt}
    function automatic logic [8:0] model_out(input int p,
                                             input logic [2:0] op,
                                             input logic z);
        logic alu;
        logic [8:0] v;
        alu  = (op >= 3'd2) && (op <= 3'd5);
        v[8] = (p <= 3);
        v[7] = (p >= 1 && p <= 3) || (p >= 5 && alu);
        v[6] = (p == 2 || p == 3);
        v[5] = (p == 4 && op != 3'd0) || (p == 6 && op == 3'd1 && z) ||
               (p == 7 && op == 3'd7);
        v[4] = (p >= 6) && (op == 3'd7);
        v[3] = (p >= 6) && (op == 3'd6);
        v[2] = (p == 7) && alu;
        v[1] = (p == 7) && (op == 3'd6);
        v[0] = (p == 4) && (op == 3'd0);
        return v;
    endfunction

    function automatic logic [8:0] dut_out();
        return {sel, rd, ld_ir, inc_pc, ld_pc, data_e, ld_ac, wr, halt};
    endfunction

    task automatic check_now(input string tag);
        chk({tag, "_out"}, 16'(dut_out()), 16'(model_out(m_ph, m_op, zero)));
        chk({tag, "_phase"}, 16'(phase), 16'(m_ph));
    endtask

    task automatic model_step();
        if (m_ph == 4 && m_op == 3'd0) begin
            halt_cnt++;
        end else begin
            if (m_ph == 3)
                m_op = opcode;
            m_ph = (m_ph + 1) % 8;
        end
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        m_ph     = 0;
        m_op     = 3'd0;
        halt_cnt = 0;
        chk("rst_out", 16'(dut_out()), 16'(9'b1_0000_0000));
        chk("rst_phase", 16'(phase), 16'd0);
        @(negedge clk);
        check_now("rst_hold");
        rst_n = 1'b1;
    endtask

    task automatic cycle(input int it);
        @(posedge clk);
        if (rst_n)
            model_step();
        #1;
        zero = 1'($urandom_range(0, 1));
        if (it == 50 || $urandom_range(0, 31) == 0)
            opcode = 3'd0;
        else
            opcode = 3'($urandom_range(1, 7));
        @(negedge clk);
        check_now("cyc");
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        opcode     = 3'd0;
        zero       = 1'b0;
        m_ph       = 0;
        m_op       = 3'd0;
        halt_cnt   = 0;
        resets_mid = 0;
        halts_seen = 0;
        #3;
        chk("init_out", 16'(dut_out()), 16'(9'b1_0000_0000));
        chk("init_phase", 16'(phase), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int it = 0; it < 4000; it++) begin
            cycle(it);
            if (halt_cnt >= 24) begin
                halts_seen++;
                do_reset();
            end else if (m_ph == 5 && $urandom_range(0, 15) == 0) begin
                resets_mid++;
                do_reset();
            end
        end

        chk("halts_seen", 16'(halts_seen > 0), 16'd1);
        chk("mid_resets", 16'(resets_mid > 0), 16'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
